// File: rtl/interface_read_if.sv
// Bundle for the FFT read-side bank interface: request channel, bank read port,
// butterfly (HRMF) output pair, external FIFO port and conflict error.
interface interface_read_if #(
    parameter int DW = 64,
    parameter int AW = 10
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic          req_dst;
    logic          rden;
    logic [AW-2:0] raddr0;
    logic [AW-2:0] raddr1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] q0_hrmf;
    logic [DW-1:0] q1_hrmf;
    logic          valid_hrmf;
    logic [DW-1:0] q0_extn;
    logic [DW-1:0] q1_extn;
    logic          valid_extn;
    logic          ready_extn;
    logic          err;

    modport master (
        input  req_valid, req_addr0, req_addr1, req_dst, rdata0, rdata1, ready_extn,
        output req_ready, rden, raddr0, raddr1, q0_hrmf, q1_hrmf, valid_hrmf,
               q0_extn, q1_extn, valid_extn, err
    );

    modport slave (
        output req_valid, req_addr0, req_addr1, req_dst, rdata0, rdata1, ready_extn,
        input  req_ready, rden, raddr0, raddr1, q0_hrmf, q1_hrmf, valid_hrmf,
               q0_extn, q1_extn, valid_extn, err
    );
endinterface

// File: rtl/interface_read.sv
// Read side of the FFT bank memory: parity-based bank mapping, fixed-latency return,
// and delivery to the butterfly or to a credit-protected first-word-fall-through FIFO.
module interface_read #(
    parameter int DW         = 64,
    parameter int AW         = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    interface_read_if.master  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = AW - 1;

    function automatic logic bank_of(input logic [AW-1:0] addr);
        return ^addr;
    endfunction

    logic [RD_LAT:0] vld_pipe_r;
    logic [RD_LAT:0] sel_pipe_r;
    logic [RD_LAT:0] dst_pipe_r;
    logic [BW-1:0]   raddr0_r;
    logic [BW-1:0]   raddr1_r;
    logic            err_r;
    logic            req_ready_r;
    logic [DW-1:0]   q0_hrmf_r;
    logic [DW-1:0]   q1_hrmf_r;
    logic            valid_hrmf_r;
    logic [DW-1:0]   q0_extn_r;
    logic [DW-1:0]   q1_extn_r;
    logic            valid_extn_r;
    logic [DW-1:0]   fifo0_r [FIFO_DEPTH];
    logic [DW-1:0]   fifo1_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   fifo_count_r;
    logic [CW-1:0]   inflight_r;

    logic            sel_s;
    logic            conflict_s;
    logic            accept_s;
    logic            issue_s;
    logic            accept_extn_s;
    logic            ret_s;
    logic [DW-1:0]   ret_q0_s;
    logic [DW-1:0]   ret_q1_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   count_nxt_s;
    logic [CW-1:0]   inflight_nxt_s;
    logic [CW:0]     credit_used_s;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic            head_from_push_s;
    logic [DW-1:0]   head_q0_s;
    logic [DW-1:0]   head_q1_s;

    // Request decode, return-side swap, FIFO/credit next-state
    always_comb begin
        sel_s          = bank_of(bus.req_addr0);
        conflict_s     = (sel_s == bank_of(bus.req_addr1));
        accept_s       = bus.req_valid && req_ready_r;
        issue_s        = accept_s && !conflict_s;
        accept_extn_s  = issue_s && !bus.req_dst;
        ret_s          = vld_pipe_r[RD_LAT];
        ret_q0_s       = sel_pipe_r[RD_LAT] ? bus.rdata1 : bus.rdata0;
        ret_q1_s       = sel_pipe_r[RD_LAT] ? bus.rdata0 : bus.rdata1;
        push_s         = ret_s && !dst_pipe_r[RD_LAT];
        pop_s          = valid_extn_r && bus.ready_extn;
        count_nxt_s    = fifo_count_r + CW'(push_s) - CW'(pop_s);
        inflight_nxt_s = inflight_r + CW'(accept_extn_s) - CW'(push_s);
        credit_used_s  = {1'b0, count_nxt_s} + {1'b0, inflight_nxt_s};
        rd_ptr_nxt_s   = rd_ptr_r + PW'(pop_s);
        // A push lands at the head when the FIFO is (or is about to become) empty
        head_from_push_s = push_s && (fifo_count_r == CW'(pop_s));
        if (head_from_push_s) begin
            head_q0_s = ret_q0_s;
            head_q1_s = ret_q1_s;
        end else begin
            head_q0_s = fifo0_r[rd_ptr_nxt_s];
            head_q1_s = fifo1_r[rd_ptr_nxt_s];
        end
    end

    // Issue stage: bank addresses, conflict error and the SEL/DST return pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r <= {(RD_LAT+1){1'b0}};
            sel_pipe_r <= {(RD_LAT+1){1'b0}};
            dst_pipe_r <= {(RD_LAT+1){1'b0}};
            raddr0_r   <= {BW{1'b0}};
            raddr1_r   <= {BW{1'b0}};
            err_r      <= 1'b0;
        end else begin
            vld_pipe_r <= {vld_pipe_r[RD_LAT-1:0], issue_s};
            sel_pipe_r <= {sel_pipe_r[RD_LAT-1:0], sel_s};
            dst_pipe_r <= {dst_pipe_r[RD_LAT-1:0], bus.req_dst};
            err_r      <= accept_s && conflict_s;
            if (issue_s) begin
                raddr0_r <= sel_s ? bus.req_addr1[AW-1:1] : bus.req_addr0[AW-1:1];
                raddr1_r <= sel_s ? bus.req_addr0[AW-1:1] : bus.req_addr1[AW-1:1];
            end
        end
    end

    // Butterfly output: one strobe per returned HRMF pair, data held between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            q0_hrmf_r    <= {DW{1'b0}};
            q1_hrmf_r    <= {DW{1'b0}};
            valid_hrmf_r <= 1'b0;
        end else begin
            valid_hrmf_r <= ret_s && dst_pipe_r[RD_LAT];
            if (ret_s && dst_pipe_r[RD_LAT]) begin
                q0_hrmf_r <= ret_q0_s;
                q1_hrmf_r <= ret_q1_s;
            end
        end
    end

    // FIFO control, registered head and credit-based request ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
            inflight_r   <= {CW{1'b0}};
            valid_extn_r <= 1'b0;
            q0_extn_r    <= {DW{1'b0}};
            q1_extn_r    <= {DW{1'b0}};
            req_ready_r  <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_r + PW'(push_s);
            rd_ptr_r     <= rd_ptr_nxt_s;
            fifo_count_r <= count_nxt_s;
            inflight_r   <= inflight_nxt_s;
            valid_extn_r <= (count_nxt_s != {CW{1'b0}});
            if (count_nxt_s != {CW{1'b0}}) begin
                q0_extn_r <= head_q0_s;
                q1_extn_r <= head_q1_s;
            end
            req_ready_r  <= (credit_used_s < (CW+1)'(FIFO_DEPTH));
        end
    end

    // FIFO storage; pointers alone define occupancy, so no reset is needed here
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo0_r[wr_ptr_r] <= ret_q0_s;
            fifo1_r[wr_ptr_r] <= ret_q1_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.rden       = vld_pipe_r[0];
    assign bus.raddr0     = raddr0_r;
    assign bus.raddr1     = raddr1_r;
    assign bus.err        = err_r;
    assign bus.q0_hrmf    = q0_hrmf_r;
    assign bus.q1_hrmf    = q1_hrmf_r;
    assign bus.valid_hrmf = valid_hrmf_r;
    assign bus.q0_extn    = q0_extn_r;
    assign bus.q1_extn    = q1_extn_r;
    assign bus.valid_extn = valid_extn_r;
endmodule

// File: tb/tb_interface_read.sv
// Directed bench for interface_read: two-bank memory model with 2-cycle latency,
// hand-computed expectations plus in-order scoreboards for both output ports.
module tb_interface_read;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int RD_LAT = 2;
    localparam int FIFO_DEPTH = 4;
    localparam logic [63:0] TAG0 = 64'hA000_0000_0000_0000;
    localparam logic [63:0] TAG1 = 64'hB000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycle = 0;

    logic [127:0] hrmf_q [$];
    logic [127:0] extn_q [$];
    int           hrmf_times [$];

    interface_read_if #(.DW(DW), .AW(AW)) bus ();

    interface_read #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Bank memory: each word encodes its bank and bank address; 2-cycle read latency
    logic          mem_en_r;
    logic [AW-2:0] mem_a0_r;
    logic [AW-2:0] mem_a1_r;
    always @(posedge clk) begin
        mem_en_r   <= bus.rden;
        mem_a0_r   <= bus.raddr0;
        mem_a1_r   <= bus.raddr1;
        bus.rdata0 <= mem_en_r ? (TAG0 | 64'(mem_a0_r)) : 64'hDEAD_DEAD_DEAD_DEAD;
        bus.rdata1 <= mem_en_r ? (TAG1 | 64'(mem_a1_r)) : 64'hDEAD_DEAD_DEAD_DEAD;
    end

    function automatic logic [63:0] word_of(input logic [AW-1:0] a);
        return ((^a) ? TAG1 : TAG0) | 64'(a[AW-1:1]);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Output scoreboards: every pair must match the next expected one in order
    logic [127:0] exp_h;
    logic [127:0] exp_e;
    always @(negedge clk) begin
        if (bus.valid_hrmf) begin
            hrmf_times.push_back(cycle);
            if (hrmf_q.size() == 0) check_eq("hrmf_spurious", 64'(bus.valid_hrmf), 64'd0);
            else begin
                exp_h = hrmf_q.pop_front();
                check_eq("hrmf_q0", bus.q0_hrmf, exp_h[127:64]);
                check_eq("hrmf_q1", bus.q1_hrmf, exp_h[63:0]);
            end
        end
        if (bus.valid_extn && bus.ready_extn) begin
            if (extn_q.size() == 0) check_eq("extn_spurious", 64'(bus.valid_extn), 64'd0);
            else begin
                exp_e = extn_q.pop_front();
                check_eq("extn_q0", bus.q0_extn, exp_e[127:64]);
                check_eq("extn_q1", bus.q1_extn, exp_e[63:0]);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic dst);
        logic ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr0 = a0;
        bus.req_addr1 = a1;
        bus.req_dst   = dst;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 64'(ok), 64'd1);
        else if ((^a0) != (^a1)) begin
            if (dst) hrmf_q.push_back({word_of(a0), word_of(a1)});
            else     extn_q.push_back({word_of(a0), word_of(a1)});
        end
    endtask

    // Offer EXTN requests for 10 cycles and count how many are accepted
    task automatic fill_extn(input int base, output int acc);
        logic          ok;
        logic [AW-1:0] a0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            a0 = AW'(base + 8 * acc + 4);
            bus.req_valid = 1'b1;
            bus.req_addr0 = a0;
            bus.req_addr1 = a0 ^ 10'h200;
            bus.req_dst   = 1'b0;
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                extn_q.push_back({word_of(a0), word_of(a0 ^ 10'h200)});
                acc++;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        int acc;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr0  = 10'h000;
        bus.req_addr1  = 10'h000;
        bus.req_dst    = 1'b0;
        bus.ready_extn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_rden", 64'(bus.rden), 64'd0);
        check_eq("rst_err", 64'(bus.err), 64'd0);
        check_eq("rst_valids", 64'({bus.valid_hrmf, bus.valid_extn}), 64'd0);
        check_eq("rst_q0_hrmf", bus.q0_hrmf, 64'd0);
        check_eq("rst_q1_extn", bus.q1_extn, 64'd0);
        check_eq("rst_raddr0", 64'(bus.raddr0), 64'd0);
        align();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Single HRMF, no swap
        bus.ready_extn = 1'b1;
        align();
        send(10'h003, 10'h001, 1'b1);
        @(negedge clk);
        check_eq("t1_rden", 64'(bus.rden), 64'd1);
        check_eq("t1_raddr0", 64'(bus.raddr0), 64'h001);
        check_eq("t1_raddr1", 64'(bus.raddr1), 64'h000);
        lat = 1;
        while (!bus.valid_hrmf && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t1_latency", 64'(lat), 64'd4);
        check_eq("t1_q0", bus.q0_hrmf, 64'hA000_0000_0000_0001);
        check_eq("t1_q1", bus.q1_hrmf, 64'hB000_0000_0000_0000);

        // Swap
        align();
        send(10'h001, 10'h003, 1'b1);
        @(negedge clk);
        check_eq("t2_raddr0", 64'(bus.raddr0), 64'h001);
        check_eq("t2_raddr1", 64'(bus.raddr1), 64'h000);
        lat = 1;
        while (!bus.valid_hrmf && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t2_latency", 64'(lat), 64'd4);
        check_eq("t2_q0", bus.q0_hrmf, 64'hB000_0000_0000_0000);
        check_eq("t2_q1", bus.q1_hrmf, 64'hA000_0000_0000_0001);

        // Conflicts on both destinations
        align();
        send(10'h000, 10'h003, 1'b1);
        @(negedge clk);
        check_eq("cf_err", 64'(bus.err), 64'd1);
        check_eq("cf_rden", 64'(bus.rden), 64'd0);
        @(negedge clk);
        check_eq("cf_err_pulse", 64'(bus.err), 64'd0);
        align();
        send(10'h000, 10'h003, 1'b0);
        @(negedge clk);
        check_eq("cf_err_extn", 64'(bus.err), 64'd1);
        check_eq("cf_rden_extn", 64'(bus.rden), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.valid_hrmf || bus.valid_extn) seen++;
        end
        check_eq("cf_no_output", 64'(seen), 64'd0);

        // Backpressure: exactly FIFO_DEPTH accepted, ready returns after first pop
        bus.ready_extn = 1'b0;
        align();
        fill_extn(0, acc);
        check_eq("bp_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        check_eq("bp_ready_low", 64'(bus.req_ready), 64'd0);
        check_eq("bp_valid_extn", 64'(bus.valid_extn), 64'd1);
        check_eq("bp_head_q0", bus.q0_extn, 64'hB000_0000_0000_0002);
        check_eq("bp_head_q1", bus.q1_extn, 64'hA000_0000_0000_0102);
        align();
        bus.ready_extn = 1'b1;
        @(negedge clk);
        check_eq("bp_ready_pre_pop", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check_eq("bp_ready_post_pop", 64'(bus.req_ready), 64'd1);
        repeat (6) @(negedge clk);
        check_eq("bp_drained", 64'(extn_q.size()), 64'd0);
        check_eq("bp_empty", 64'(bus.valid_extn), 64'd0);

        // Mixed stream with toggling consumer
        hrmf_times.delete();
        align();
        for (int i = 0; i < 8; i++) begin
            bus.ready_extn = (i % 2 == 1);
            send(AW'(32 + 3 * i), AW'(32 + 3 * i) ^ 10'h100, (i % 2 == 0));
        end
        repeat (8) begin
            bus.ready_extn = ~bus.ready_extn;
            align();
        end
        bus.ready_extn = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("mx_hrmf_left", 64'(hrmf_q.size()), 64'd0);
        check_eq("mx_extn_left", 64'(extn_q.size()), 64'd0);
        check_eq("mx_hrmf_count", 64'(hrmf_times.size()), 64'd4);
        for (int i = 1; i < hrmf_times.size(); i++)
            check_eq("mx_hrmf_spacing", 64'(hrmf_times[i] - hrmf_times[i-1]), 64'd2);

        // Reset with requests in flight
        align();
        send(10'h010, 10'h011, 1'b1);
        send(10'h020, 10'h021, 1'b0);
        send(10'h030, 10'h031, 1'b1);
        align();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        hrmf_q.delete();
        extn_q.delete();
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.valid_hrmf || bus.valid_extn) seen++;
        end
        check_eq("rs_no_output", 64'(seen), 64'd0);
        check_eq("rs_ready", 64'(bus.req_ready), 64'd1);
        bus.ready_extn = 1'b0;
        align();
        fill_extn(64, acc);
        check_eq("rs_credit_full", 64'(acc), 64'd4);
        bus.ready_extn = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("rs_drained", 64'(extn_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
